rom_read_arbiter: RTL and testbench
===================================

Name: rom_read_arbiter

Overview:
- Shares one synchronous single-port ROM (registered read, 1-cycle latency) between NUM_REQ requesters, e.g. pattern fetch and column-data fetch in the hologram display path.
- Requesters post burst reads: start address plus beat count.
- Grants are round-robin at burst boundaries; the block issues one address per cycle and returns tagged data with a fixed 2-cycle latency.

Parameters:
- DATA_WIDTH, 8, ROM word width
- ADDRESS_WIDTH, 8, ROM address width
- DEPTH, 256, ROM words; need not be a power of two
- NUM_REQ, 2, number of requesters (>=2)
- LEN_WIDTH, 8, burst length field width; field value = beats-1

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester burst request
- req_addr  in  NUM_REQ*ADDRESS_WIDTH  start address; requester i at slice [i*ADDRESS_WIDTH +: ADDRESS_WIDTH]
- req_len  in  NUM_REQ*LEN_WIDTH  beats-1, sliced the same way
- req_ready  out  NUM_REQ  one-hot accept strobe
- rom_addr  out  ADDRESS_WIDTH  to ROM addr
- rom_data  in  DATA_WIDTH  from ROM dataOut
- resp_valid  out  NUM_REQ  one-hot, one beat of data for requester i
- resp_data  out  DATA_WIDTH  returned word
- resp_last  out  1  final beat of the burst
- busy  out  1  burst active or any beat in flight

Behaviour:
- Reset (async assert, sync-safe release):
  - state=IDLE; req_ready=0; resp_valid=0; resp_data=0; resp_last=0; rom_addr=0; busy=0.
  - Pipeline valid bits are cleared and in-flight beats are dropped.
  - Round-robin pointer is reset so requester 0 has highest priority.
- IDLE state:
  - If any req_valid is high, select g = first valid requester starting at (last_grant+1) mod NUM_REQ.
  - req_ready[g]=1 combinationally in the same cycle T; handshake completes at the edge ending T.
  - rom_addr = req_addr[g] in T (beat 0 issued in T).
  - Latch g, next address, and remaining count = req_len[g].
  - If req_len[g]==0, stay in IDLE; otherwise go to BURST.
  - If no request, rom_addr holds its last value.
- BURST state:
  - One beat per cycle; rom_addr = registered address counter.
  - Next address = (addr==DEPTH-1) ? 0 : addr+1. Wrap is at DEPTH-1, not at 2^ADDRESS_WIDTH.
  - On the final beat, return to IDLE. The next cycle may accept a new burst, so there are zero bubbles between back-to-back bursts.
  - req_ready is 0 for all requesters throughout BURST.
- Issue pipeline:
  - Stage 1 (T+1) registers valid, id, and last flag while the ROM presents rom_data.
  - Stage 2 (T+2) registers rom_data into resp_data and drives resp_valid[id] and resp_last.
  - Latency from address issue to resp_valid is exactly 2 cycles. Throughput is 1 beat/cycle.
- Responses have no backpressure; requesters must sink every beat.
- Requesters must hold req_addr/req_len stable while req_valid=1 and req_ready=0. Dropping req_valid before grant is legal.
- last_grant updates only on an accepted handshake.
- Simultaneous events: a requester whose response is still returning may re-request; it is arbitrated normally.
- Reset mid-burst: all outputs go to reset values immediately, with no stale responses after release.
- busy = (state==BURST) | stage1_valid | stage2_valid.

Decomposition:
- Package rom_arb_pkg holds:
  - state enum {IDLE, BURST}
  - helper function next_addr(addr, DEPTH) implementing the wrap rule
- Sub-module rr_arbiter (NUM_REQ): takes the request vector plus last_grant pointer and produces a one-hot grant plus an encoded index. The pointer update stays in the parent.
- The ROM itself is instantiated outside this block.

Test Plan:
Bench ROM loaded with mem[i]=i.
- Reset: hold rst_n=0 with req_valid=2'b11 -> req_ready=0, resp_valid=0, resp_data=0, busy=0.
- Single beat: req0 addr=0x10 len=0 at T -> req_ready=2'b01 at T, rom_addr=0x10 at T, resp_valid=2'b01 at T+2, resp_data=0x10, resp_last=1.
- Wrap burst: req1 addr=0xFE len=3 -> rom_addr FE,FF,00,01 on consecutive cycles; resp_data FE,FF,00,01; resp_last only on beat 4.
- Contention: both valid from reset, each len=1 -> req0 granted first; req1 granted on the cycle after req0's second beat, with no bubble. Re-request both -> req0 granted.
- Non-power-of-two: DEPTH=200, req0 addr=199 len=1 -> rom_addr 199 then 0.
- Mid-burst reset: req0 addr=0 len=5, drop rst_n during beat 3 -> resp_valid=0 immediately. After release: IDLE, no further resp_valid until a new request.

Source files
------------

// File: rtl/rom_arb_pkg.sv
// Shared types and the address-wrap helper for the ROM read arbiter.
// The ROM depth need not be a power of two, so wrap is an explicit compare.
package rom_arb_pkg;

  typedef enum logic {IDLE, BURST} state_e;

  function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [31:0] depth);
    return (addr == depth - 32'd1) ? 32'd0 : addr + 32'd1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin request picker: first active requester after last_grant.
// Purely combinational; the owner keeps and updates the pointer.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      grant_idx,
  output logic               grant_valid
);

  int cand;

  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    cand        = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(last_grant) + k) % NUM_REQ;
      if (!grant_valid && req[cand]) begin
        grant[cand] = 1'b1;
        grant_idx   = IW'(cand);
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rom_read_arbiter.sv
// Shares one registered-read ROM between NUM_REQ burst requesters with
// round-robin grants at burst boundaries and fixed 2-cycle tagged returns.
module rom_read_arbiter
  import rom_arb_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 8,
  parameter int DEPTH         = 256,
  parameter int NUM_REQ       = 2,
  parameter int LEN_WIDTH     = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]     req_len,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic [ADDRESS_WIDTH-1:0]         rom_addr,
  input  logic [DATA_WIDTH-1:0]            rom_data,
  output logic [NUM_REQ-1:0]               resp_valid,
  output logic [DATA_WIDTH-1:0]            resp_data,
  output logic                             resp_last,
  output logic                             busy
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_e                   state_q, state_d;
  logic                     run_q;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d, rom_addr_q, rom_addr_d;
  logic [LEN_WIDTH-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]            gid_q, gid_d, last_grant_q, last_grant_d;
  logic                     s1_valid_q, s1_valid_d, s1_last_q, s1_last_d;
  logic [IW-1:0]            s1_id_q, s1_id_d;
  logic [NUM_REQ-1:0]       resp_valid_q, resp_valid_d;
  logic [DATA_WIDTH-1:0]    resp_data_q, resp_data_d;
  logic                     resp_last_q, resp_last_d;

  logic [NUM_REQ-1:0]       grant;
  logic [IW-1:0]            grant_idx;
  logic                     grant_any;
  logic [ADDRESS_WIDTH-1:0] sel_addr, issue_addr;
  logic [LEN_WIDTH-1:0]     sel_len;
  logic                     issue, issue_last;
  logic [IW-1:0]            issue_id;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .grant_valid(grant_any)
  );

  assign sel_addr = req_addr[int'(grant_idx)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
  assign sel_len  = req_len[int'(grant_idx)*LEN_WIDTH +: LEN_WIDTH];

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    cnt_d        = cnt_q;
    gid_d        = gid_q;
    last_grant_d = last_grant_q;
    rom_addr_d   = rom_addr_q;
    req_ready    = '0;
    issue        = 1'b0;
    issue_last   = 1'b0;
    issue_id     = gid_q;
    issue_addr   = rom_addr_q;
    case (state_q)
      IDLE: begin
        // run_q keeps grants off until the first edge after reset release
        if (run_q && grant_any) begin
          req_ready    = grant;
          issue        = 1'b1;
          issue_id     = grant_idx;
          issue_addr   = sel_addr;
          issue_last   = (sel_len == '0);
          last_grant_d = grant_idx;
          gid_d        = grant_idx;
          addr_d       = ADDRESS_WIDTH'(next_addr(32'(sel_addr), 32'(DEPTH)));
          cnt_d        = sel_len;
          if (sel_len != '0) state_d = BURST;
        end
      end
      BURST: begin
        issue      = 1'b1;
        issue_addr = addr_q;
        issue_last = (cnt_q == LEN_WIDTH'(1));
        cnt_d      = cnt_q - LEN_WIDTH'(1);
        addr_d     = ADDRESS_WIDTH'(next_addr(32'(addr_q), 32'(DEPTH)));
        if (issue_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (issue) rom_addr_d = issue_addr;

    s1_valid_d   = issue;
    s1_id_d      = issue_id;
    s1_last_d    = issue_last;
    resp_valid_d = '0;
    if (s1_valid_q) resp_valid_d[s1_id_q] = 1'b1;
    resp_data_d  = s1_valid_q ? rom_data : resp_data_q;
    resp_last_d  = s1_valid_q & s1_last_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      run_q        <= 1'b0;
      addr_q       <= '0;
      rom_addr_q   <= '0;
      cnt_q        <= '0;
      gid_q        <= '0;
      last_grant_q <= IW'(NUM_REQ - 1);
      s1_valid_q   <= 1'b0;
      s1_id_q      <= '0;
      s1_last_q    <= 1'b0;
      resp_valid_q <= '0;
      resp_data_q  <= '0;
      resp_last_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      run_q        <= 1'b1;
      addr_q       <= addr_d;
      rom_addr_q   <= rom_addr_d;
      cnt_q        <= cnt_d;
      gid_q        <= gid_d;
      last_grant_q <= last_grant_d;
      s1_valid_q   <= s1_valid_d;
      s1_id_q      <= s1_id_d;
      s1_last_q    <= s1_last_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_last_q  <= resp_last_d;
    end
  end

  assign rom_addr   = issue_addr;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_last  = resp_last_q;
  assign busy       = (state_q == BURST) | s1_valid_q | (|resp_valid_q);

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Directed bench for rom_read_arbiter: two instances (DEPTH 256 and 200),
// each with a registered-read ROM model holding mem[i]=i.
module tb_rom_read_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid, req_ready, resp_valid;
  logic [15:0] req_addr, req_len;
  logic [7:0]  rom_addr, rom_data, resp_data;
  logic        resp_last, busy;

  logic [1:0]  v2, rdy2, rv2;
  logic [15:0] a2, l2;
  logic [7:0]  ra2, rd2, rdat2;
  logic        rl2, busy2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rom_read_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
    .req_len(req_len), .req_ready(req_ready), .rom_addr(rom_addr),
    .rom_data(rom_data), .resp_valid(resp_valid), .resp_data(resp_data),
    .resp_last(resp_last), .busy(busy)
  );

  rom_read_arbiter #(.DEPTH(200)) dut2 (
    .clk(clk), .rst_n(rst_n), .req_valid(v2), .req_addr(a2),
    .req_len(l2), .req_ready(rdy2), .rom_addr(ra2),
    .rom_data(rd2), .resp_valid(rv2), .resp_data(rdat2),
    .resp_last(rl2), .busy(busy2)
  );

  always_ff @(posedge clk) begin
    rom_data <= rom_addr;
    rd2      <= ra2;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 2'b11;
    req_addr  = {8'h30, 8'h20};
    req_len   = {8'd1, 8'd1};
    v2 = 2'b00; a2 = '0; l2 = '0;
    tick(); tick();
    chk("rst_ready", req_ready, 2'b00);
    chk("rst_resp_valid", resp_valid, 2'b00);
    chk("rst_resp_data", resp_data, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rom_addr", rom_addr, 8'h00);

    // contention: both valid straight out of reset, len=1 each
    rst_n = 1'b1;
    tick();
    #1;
    chk("cont_ready0", req_ready, 2'b01);
    chk("cont_addr0", rom_addr, 8'h20);
    tick();
    req_valid = 2'b10;
    #1;
    chk("cont_burst_ready", req_ready, 2'b00);
    chk("cont_addr1", rom_addr, 8'h21);
    tick();
    chk("cont_ready1", req_ready, 2'b10);
    chk("cont_addr2", rom_addr, 8'h30);
    chk("cont_resp0_valid", resp_valid, 2'b01);
    chk("cont_resp0_data", resp_data, 8'h20);
    chk("cont_resp0_last", resp_last, 1'b0);
    tick();
    req_valid = 2'b00;
    chk("cont_addr3", rom_addr, 8'h31);
    chk("cont_resp1_data", resp_data, 8'h21);
    chk("cont_resp1_last", resp_last, 1'b1);
    tick();
    chk("cont_resp2_valid", resp_valid, 2'b10);
    chk("cont_resp2_data", resp_data, 8'h30);
    req_valid = 2'b11;
    req_len   = {8'd0, 8'd0};
    #1;
    chk("rereq_ready0", req_ready, 2'b01);
    tick();
    req_valid = 2'b10;
    #1;
    chk("rereq_ready1", req_ready, 2'b10);
    tick();
    req_valid = 2'b00;
    tick(); tick(); tick();
    chk("idle_busy", busy, 1'b0);

    // single beat
    req_valid = 2'b01;
    req_addr  = {8'h00, 8'h10};
    req_len   = {8'd0, 8'd0};
    #1;
    chk("single_ready", req_ready, 2'b01);
    chk("single_addr", rom_addr, 8'h10);
    chk("single_busy_t", busy, 1'b0);
    tick();
    req_valid = 2'b00;
    chk("single_busy_t1", busy, 1'b1);
    tick();
    chk("single_resp_valid", resp_valid, 2'b01);
    chk("single_resp_data", resp_data, 8'h10);
    chk("single_resp_last", resp_last, 1'b1);
    tick();

    // wrap burst through the top of a 256-word ROM
    req_valid = 2'b10;
    req_addr  = {8'hFE, 8'h00};
    req_len   = {8'd3, 8'd0};
    #1;
    chk("wrap_ready", req_ready, 2'b10);
    chk("wrap_addr0", rom_addr, 8'hFE);
    tick();
    req_valid = 2'b00;
    chk("wrap_addr1", rom_addr, 8'hFF);
    tick();
    chk("wrap_addr2", rom_addr, 8'h00);
    chk("wrap_d0", resp_data, 8'hFE);
    chk("wrap_v0", resp_valid, 2'b10);
    chk("wrap_l0", resp_last, 1'b0);
    tick();
    chk("wrap_addr3", rom_addr, 8'h01);
    chk("wrap_d1", resp_data, 8'hFF);
    chk("wrap_l1", resp_last, 1'b0);
    tick();
    chk("wrap_d2", resp_data, 8'h00);
    chk("wrap_l2", resp_last, 1'b0);
    tick();
    chk("wrap_d3", resp_data, 8'h01);
    chk("wrap_l3", resp_last, 1'b1);
    chk("wrap_hold_addr", rom_addr, 8'h01);
    tick();
    chk("wrap_done_valid", resp_valid, 2'b00);
    chk("wrap_done_busy", busy, 1'b0);

    // non-power-of-two depth wraps at 199
    v2 = 2'b01;
    a2 = {8'h00, 8'd199};
    l2 = {8'd0, 8'd1};
    #1;
    chk("np2_ready", rdy2, 2'b01);
    chk("np2_addr0", ra2, 8'd199);
    tick();
    v2 = 2'b00;
    chk("np2_addr1", ra2, 8'd0);
    tick();
    chk("np2_d0", rdat2, 8'd199);
    tick();
    chk("np2_d1", rdat2, 8'd0);
    chk("np2_l1", rl2, 1'b1);
    tick();

    // reset during beat 3 of a 6-beat burst
    req_valid = 2'b01;
    req_addr  = {8'h00, 8'h00};
    req_len   = {8'd0, 8'd5};
    #1;
    chk("mid_ready", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    chk("mid_addr1", rom_addr, 8'h01);
    tick();
    chk("mid_addr2", rom_addr, 8'h02);
    chk("mid_pre_valid", resp_valid, 2'b01);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", resp_valid, 2'b00);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_addr", rom_addr, 8'h00);
    chk("mid_rst_last", resp_last, 1'b0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("post_rst_valid", resp_valid, 2'b00);
      chk("post_rst_busy", busy, 1'b0);
    end
    req_valid = 2'b01;
    req_addr  = {8'h00, 8'h42};
    req_len   = {8'd0, 8'd0};
    #1;
    chk("post_rst_ready", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    tick();
    chk("post_rst_data", resp_data, 8'h42);
    chk("post_rst_resp", resp_valid, 2'b01);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
